// File: rtl/scm_reader_pkg.sv
// scm_reader_pkg: types and constants shared by the window reader sources.
//   state_t      reader FSM states
//   FIFO_DEPTH   number of window buffers (issued reads that still need a slot)
//   win_entry_t  one buffered window plus its end-of-command flag
// The entry width follows the DEF_* constants. The top level takes the same
// values as its parameter defaults, so change both together.
package scm_reader_pkg;

  localparam int DEF_ADDR_WIDTH   = 5;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_ASYMM_FACTOR = 3;
  localparam int DEF_LEN_WIDTH    = 8;
  localparam int WIN_WIDTH        = DEF_ASYMM_FACTOR * DEF_DATA_WIDTH;

  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIN_WIDTH-1:0] data;
    logic                 last;
  } win_entry_t;

endpackage

// File: rtl/scm_window_reader_if.sv
// scm_window_reader_if: command and window stream of the window reader.
//   cmd_*  command channel (producer -> reader): start address, stride, window count
//   win_*  window stream (reader -> consumer): ASYMM_FACTOR words, last flag
// Handshake: both channels transfer on a rising clk edge where valid and
// ready are both high. A source holds valid and its payload stable until
// that transfer happens. Ready may change freely and is never a function
// of the same channel's valid.
interface scm_window_reader_if #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int ASYMM_FACTOR = 3,
  parameter int LEN_WIDTH    = 8
);

  logic                               cmd_valid_i;
  logic                               cmd_ready_o;
  logic [ADDR_WIDTH-1:0]              cmd_addr_i;
  logic [ADDR_WIDTH-1:0]              cmd_stride_i;
  logic [LEN_WIDTH-1:0]               cmd_len_i;

  logic                               win_valid_o;
  logic                               win_ready_i;
  logic [ASYMM_FACTOR*DATA_WIDTH-1:0] win_data_o;
  logic                               win_last_o;

  // Reader side.
  modport slave (
    input  cmd_valid_i, cmd_addr_i, cmd_stride_i, cmd_len_i, win_ready_i,
    output cmd_ready_o, win_valid_o, win_data_o, win_last_o
  );

  // Command producer / window consumer side.
  modport master (
    output cmd_valid_i, cmd_addr_i, cmd_stride_i, cmd_len_i, win_ready_i,
    input  cmd_ready_o, win_valid_o, win_data_o, win_last_o
  );

endinterface

// File: rtl/scm_window_fifo.sv
// scm_window_fifo: 2-entry flop FIFO that holds returned windows.
//   clk, rst   clock, asynchronous active-high reset
//   push       write pushEntry at the tail
//   pop        drop the head entry (only while notEmpty)
//   pushEntry  incoming window and last flag
//   headEntry  current head. It holds stable until popped.
//   occ        number of stored entries (0..2)
//   notEmpty   at least one entry is stored
// A push and a pop in the same cycle are allowed even when the FIFO is full.
// The upstream issue logic never pushes into a full FIFO without a pop.
module scm_window_fifo
  import scm_reader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  win_entry_t pushEntry,
  output win_entry_t headEntry,
  output logic [1:0] occ,
  output logic       notEmpty
);

  win_entry_t slots [FIFO_DEPTH];
  // With two slots, a single bit addresses either one.
  logic       wrPtr;
  logic       rdPtr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) slots[i] <= '0;
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      occ   <= 2'd0;
    end else begin
      if (push) begin
        slots[wrPtr] <= pushEntry;
        wrPtr        <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign headEntry = slots[rdPtr];
  assign notEmpty  = (occ != 2'd0);

endmodule

// File: rtl/scm_window_reader.sv
// scm_window_reader: streaming read sequencer for the wide read port of the
// SCM register file. It takes one command (base, stride, count) and issues one
// wide read per window. The returned windows go out as a backpressured stream.
//   clk, rst      clock, asynchronous active-high reset
//   bus           command channel and window stream (slave side)
//   mem_ren_o     ReadEnable_b of the register file
//   mem_raddr_o   ReadAddr_b. It is 0 whenever mem_ren_o is low.
//   mem_rdata_i   ReadData_b. It is valid the cycle after mem_ren_o.
//   done_o        one-cycle pulse when the command has fully completed
//   dbgState      current FSM state
module scm_window_reader
  import scm_reader_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ASYMM_FACTOR = DEF_ASYMM_FACTOR,
  parameter int LEN_WIDTH    = DEF_LEN_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  scm_window_reader_if.slave                 bus,
  output logic                               mem_ren_o,
  output logic [ADDR_WIDTH-1:0]              mem_raddr_o,
  input  logic [ASYMM_FACTOR*DATA_WIDTH-1:0] mem_rdata_i,
  output logic                               done_o,
  output state_t                             dbgState
);

  state_t                state, stateNext;
  logic [ADDR_WIDTH-1:0] curAddr, strideQ;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  inflight, inflightLast, doneZero;
  logic [1:0]            occ;
  logic                  notEmpty, pop, issue, accept, cmdReady, drained;
  win_entry_t            pushEntry, headEntry;

  assign pop     = bus.win_valid_o & bus.win_ready_i;
  // Nothing is buffered and no read is in flight. An empty FIFO cannot pop.
  assign drained = (occ == 2'd0) && !inflight;
  // The reader takes a new command in the same cycle it reports
  // completion. That cycle is the bubble between back-to-back commands.
  assign cmdReady = (state == IDLE) || ((state == DRAIN) && drained);
  assign accept   = bus.cmd_valid_i & cmdReady;

  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (bus.cmd_len_i != '0)) stateNext = RUN;
      end
      RUN: begin
        // Credit check: buffered + in flight, minus the window leaving now,
        // must stay below two.
        issue = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
        if (issue && (remaining == LEN_WIDTH'(1))) stateNext = DRAIN;
      end
      DRAIN: begin
        if (drained) stateNext = (accept && (bus.cmd_len_i != '0)) ? RUN : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      curAddr      <= '0;
      strideQ      <= '0;
      remaining    <= '0;
      inflight     <= 1'b0;
      inflightLast <= 1'b0;
      doneZero     <= 1'b0;
    end else begin
      state        <= stateNext;
      inflight     <= issue;
      inflightLast <= issue && (remaining == LEN_WIDTH'(1));
      doneZero     <= accept && (bus.cmd_len_i == '0);
      if (accept) begin
        curAddr   <= bus.cmd_addr_i;
        strideQ   <= bus.cmd_stride_i;
        remaining <= bus.cmd_len_i;
      end else if (issue) begin
        curAddr   <= curAddr + strideQ;
        remaining <= remaining - LEN_WIDTH'(1);
      end
    end
  end

  assign pushEntry = '{data: mem_rdata_i, last: inflightLast};

  scm_window_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .pop       (pop),
    .pushEntry (pushEntry),
    .headEntry (headEntry),
    .occ       (occ),
    .notEmpty  (notEmpty)
  );

  assign mem_ren_o       = issue;
  assign mem_raddr_o     = issue ? curAddr : '0;
  assign bus.cmd_ready_o = cmdReady;
  assign bus.win_valid_o = notEmpty;
  assign bus.win_data_o  = headEntry.data;
  assign bus.win_last_o  = headEntry.last;
  assign done_o          = doneZero || ((state == DRAIN) && drained);
  assign dbgState        = state;

endmodule

// File: tb/tb_scm_window_reader.sv
// tb_scm_window_reader: self-checking bench for scm_window_reader.
// A behavioural register-file model answers the wide reads. A scoreboard
// holds the expected address sequence and the expected windows. These are
// built from the command rules (base + i*stride mod NUM_WORDS, circular
// words). A monitor checks every read, every window handshake, the credit
// bound and the done_o timing.
module tb_scm_window_reader;
  import scm_reader_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int AF = 3;
  localparam int LW = 8;
  localparam int NW = 1 << AW;
  localparam int WW = AF * DW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_ren_o;
  logic [AW-1:0] mem_raddr_o;
  logic [WW-1:0] mem_rdata_i = '0;
  logic          done_o;
  state_t        dbgState;

  always #5 clk = ~clk;

  scm_window_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ASYMM_FACTOR(AF), .LEN_WIDTH(LW)) bus ();

  scm_window_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ASYMM_FACTOR(AF), .LEN_WIDTH(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .mem_ren_o   (mem_ren_o),
    .mem_raddr_o (mem_raddr_o),
    .mem_rdata_i (mem_rdata_i),
    .done_o      (done_o),
    .dbgState    (dbgState)
  );

  // ---------------- counters and scoreboard ----------------
  int checks = 0;
  int fails  = 0;

  logic [WW:0]   exp_q[$];   // {last, window}
  logic [AW-1:0] addr_q[$];
  int            renCycles[$];
  int            popCycles[$];
  int            cycle = 0;
  int            issued = 0;
  int            popped = 0;
  int            doneCount = 0;
  bit            expectDone = 1'b0;
  logic [WW:0]   expHead;
  int            readyMode = 0;  // 0: bench drives win_ready_i, 1: random

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- register file model ----------------
  logic [DW-1:0] memWords [NW];
  logic          pendRen = 1'b0;
  logic [AW-1:0] pendAddr = '0;

  function automatic logic [WW-1:0] window_of(input int a);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < AF; k++) w[k*DW +: DW] = memWords[(a + k) % NW];
    return w;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      pendRen  = mem_ren_o;
      pendAddr = mem_raddr_o;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (pendRen) mem_rdata_i <= window_of(int'(pendAddr));
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (rst) begin
        expectDone = 1'b0;
        issued     = 0;
        popped     = 0;
      end else begin
        check("done_o", done_o, expectDone);
        if (done_o) doneCount++;
        expectDone = 1'b0;
        if (bus.cmd_valid_i && bus.cmd_ready_o && (bus.cmd_len_i == '0)) expectDone = 1'b1;
        if (mem_ren_o) begin
          issued++;
          renCycles.push_back(cycle);
          check("ren_expected", addr_q.size() > 0, 1);
          if (addr_q.size() > 0) check("mem_raddr", mem_raddr_o, addr_q.pop_front());
        end
        if (bus.win_valid_o) check("window_expected", exp_q.size() > 0, 1);
        if (bus.win_valid_o && bus.win_ready_i && (exp_q.size() > 0)) begin
          expHead = exp_q.pop_front();
          popped++;
          popCycles.push_back(cycle);
          check("win_data", bus.win_data_o, expHead[WW-1:0]);
          check("win_last", bus.win_last_o, expHead[WW]);
          if (expHead[WW]) expectDone = 1'b1;
        end
        if (mem_ren_o) check("credit_bound", (issued - popped) <= 2, 1);
      end
    end
  end

  // ---------------- ready generator ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (readyMode == 1) bus.win_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached with %0d checks", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic expect_cmd(input int a, input int s, input int n);
    for (int i = 0; i < n; i++) begin
      int wa;
      wa = (a + i * s) % NW;
      addr_q.push_back(AW'(wa));
      exp_q.push_back({(i == n - 1), window_of(wa)});
    end
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [AW-1:0] s, input logic [LW-1:0] n);
    bit acc;
    acc = 1'b0;
    @(posedge clk);
    #1;
    bus.cmd_addr_i   = a;
    bus.cmd_stride_i = s;
    bus.cmd_len_i    = n;
    bus.cmd_valid_i  = 1'b1;
    for (int b = 0; b < 200; b++) begin
      @(negedge clk);
      if (bus.cmd_ready_o) begin
        acc = 1'b1;
        break;
      end
    end
    check("cmd_accepted", acc, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target);
    bit seen;
    seen = 1'b0;
    for (int b = 0; b < 400; b++) begin
      @(posedge clk);
      if (doneCount >= target) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1);
    #1;
    check("addr_q_drained", addr_q.size(), 0);
    check("exp_q_drained", exp_q.size(), 0);
    check("state_idle", dbgState, IDLE);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready_o, 1);
    check({tag, "_mem_ren"}, mem_ren_o, 0);
    check({tag, "_mem_raddr"}, mem_raddr_o, 0);
    check({tag, "_win_valid"}, bus.win_valid_o, 0);
    check({tag, "_win_data"}, bus.win_data_o, 0);
    check({tag, "_win_last"}, bus.win_last_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_state"}, dbgState, IDLE);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [AW-1:0]      addr;
    logic [AW-1:0]      stride;
    logic [LW-1:0]      len;
    int                 nAddr;
    logic [7:0][AW-1:0] expAddr;   // element 0 is the rightmost field
    bit                 checkRate;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base;
    logic [WW-1:0] firstData;
    bit found;

    for (int i = 0; i < NW; i++) memWords[i] = $urandom;
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_addr_i   = '0;
    bus.cmd_stride_i = '0;
    bus.cmd_len_i    = '0;
    bus.win_ready_i  = 1'b1;

    vecs[0] = '{addr: 5'd5,  stride: 5'd1,  len: 8'd4, nAddr: 4,
                expAddr: {5'd0, 5'd0, 5'd0, 5'd0, 5'd8, 5'd7, 5'd6, 5'd5}, checkRate: 1'b1};
    vecs[1] = '{addr: 5'd30, stride: 5'd1,  len: 8'd3, nAddr: 3,
                expAddr: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd30}, checkRate: 1'b0};
    vecs[2] = '{addr: 5'd2,  stride: 5'd31, len: 8'd4, nAddr: 4,
                expAddr: {5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd0, 5'd1, 5'd2}, checkRate: 1'b0};
    vecs[3] = '{addr: 5'd9,  stride: 5'd0,  len: 8'd3, nAddr: 3,
                expAddr: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 5'd9, 5'd9}, checkRate: 1'b0};
    vecs[4] = '{addr: 5'd17, stride: 5'd4,  len: 8'd0, nAddr: 0,
                expAddr: '0, checkRate: 1'b0};
    vecs[5] = '{addr: 5'd28, stride: 5'd7,  len: 8'd6, nAddr: 6,
                expAddr: {5'd0, 5'd0, 5'd31, 5'd24, 5'd17, 5'd10, 5'd3, 5'd28}, checkRate: 1'b1};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven commands with the consumer always ready.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].nAddr; i++) begin
        addr_q.push_back(vecs[v].expAddr[i]);
        exp_q.push_back({(i == vecs[v].nAddr - 1), window_of(int'(vecs[v].expAddr[i]))});
      end
      renCycles.delete();
      popCycles.delete();
      base = doneCount;
      send_cmd(vecs[v].addr, vecs[v].stride, vecs[v].len);
      wait_done(base + 1);
      if (vecs[v].checkRate) begin
        check("ren_count", renCycles.size(), vecs[v].nAddr);
        check("pop_count", popCycles.size(), vecs[v].nAddr);
        for (int i = 1; i < renCycles.size(); i++)
          check("ren_back_to_back", renCycles[i] - renCycles[i-1], 1);
        for (int i = 1; i < popCycles.size(); i++)
          check("win_back_to_back", popCycles[i] - popCycles[i-1], 1);
        if (renCycles.size() > 0 && popCycles.size() > 0)
          check("first_window_latency", popCycles[0] - renCycles[0], 2);
      end
    end

    // Backpressure: consumer stalls for 5 cycles once the first window is up.
    @(posedge clk);
    #1;
    bus.win_ready_i = 1'b0;
    expect_cmd(12, 3, 6);
    base = doneCount;
    send_cmd(5'd12, 5'd3, 8'd6);
    found = 1'b0;
    for (int b = 0; b < 50; b++) begin
      @(negedge clk);
      if (bus.win_valid_o) begin
        found = 1'b1;
        break;
      end
    end
    check("stall_first_valid", found, 1);
    firstData = bus.win_data_o;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("stall_no_ren", mem_ren_o, 0);
      check("stall_valid", bus.win_valid_o, 1);
      check("stall_data_stable", bus.win_data_o, firstData);
    end
    check("stall_held_windows", issued - popped, 2);
    @(posedge clk);
    #1;
    bus.win_ready_i = 1'b1;
    wait_done(base + 1);

    // Second command raised early: accepted in the cycle done_o pulses.
    expect_cmd(3, 1, 2);
    expect_cmd(20, 2, 2);
    base = doneCount;
    send_cmd(5'd3, 5'd1, 8'd2);
    @(posedge clk);
    #1;
    bus.cmd_addr_i   = 5'd20;
    bus.cmd_stride_i = 5'd2;
    bus.cmd_len_i    = 8'd2;
    bus.cmd_valid_i  = 1'b1;
    found = 1'b0;
    for (int b = 0; b < 50; b++) begin
      @(negedge clk);
      if (bus.cmd_ready_o) begin
        found = 1'b1;
        break;
      end
    end
    check("b2b_accepted", found, 1);
    check("b2b_accept_on_done", done_o, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b0;
    wait_done(base + 2);

    // Reset in the middle of a 5-window command.
    expect_cmd(7, 5, 5);
    send_cmd(5'd7, 5'd5, 8'd5);
    found = 1'b0;
    for (int b = 0; b < 50; b++) begin
      @(posedge clk);
      if (popped >= 2) begin
        found = 1'b1;
        break;
      end
    end
    check("mid_reset_two_windows", found, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("mid_reset");
    addr_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_cmd(1, 1, 3);
    base = doneCount;
    send_cmd(5'd1, 5'd1, 8'd3);
    wait_done(base + 1);

    // Random commands with a random consumer.
    readyMode = 1;
    for (int t = 0; t < 12; t++) begin
      int a, s, n;
      a = $urandom_range(0, NW - 1);
      s = $urandom_range(0, NW - 1);
      n = $urandom_range(0, 9);
      memWords[$urandom_range(0, NW - 1)] = $urandom;
      expect_cmd(a, s, n);
      base = doneCount;
      send_cmd(AW'(a), AW'(s), LW'(n));
      wait_done(base + 1);
    end
    readyMode = 0;
    @(posedge clk);
    #2;
    bus.win_ready_i = 1'b1;

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
